mult_arbiter: RTL

- Round-robin arbiter and sequencer that shares one sequential 8x8 multiplier (start/done handshake, 16-bit product) among NUM_REQ requesters.
- Accepts one operand pair at a time, launches the multiplier, waits for done with a timeout, then returns a tagged result.
- Sits between the requesting client blocks and the multiplier's controller/datapath.

---
 rtl/mult_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// Round-robin sequencer sharing one start/done 8x8 multiplier among NUM_REQ clients.
// Each grant is latched in IDLE, launched, awaited with a timeout, then returned as a tagged response.
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset_a,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 mult_start,
    output logic [7:0]           mult_dataa,
    output logic [7:0]           mult_datab,
    input  logic                 mult_done,
    input  logic [15:0]          mult_product,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_product,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [1:0]           state_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LAUNCH = 2'b01,
        WAIT   = 2'b10,
        RESP   = 2'b11
    } state_t;

    state_t          state;
    logic [ID_W-1:0] id;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] win_id;
    logic            win_found;
    logic [7:0]      timer;
    logic [7:0]      a_arr [NUM_REQ];
    logic [7:0]      b_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = req_a[8*i +: 8];
            b_arr[i] = req_b[8*i +: 8];
        end
    end

    // Scan starting just after the previous winner so every client gets its turn.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!win_found && req_valid[idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_a) begin
            state       <= IDLE;
            timer       <= 8'd0;
            last_grant  <= ID_W'(NUM_REQ - 1);
            id          <= '0;
            mult_dataa  <= 8'd0;
            mult_datab  <= 8'd0;
            rsp_id      <= '0;
            rsp_product <= 16'd0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        id         <= win_id;
                        mult_dataa <= a_arr[win_id];
                        mult_datab <= b_arr[win_id];
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer <= 8'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    // Done has priority over an expiring timer; timer counts 0..TIMEOUT-1.
                    if (mult_done) begin
                        rsp_product <= mult_product;
                        rsp_err     <= 1'b0;
                        rsp_id      <= id;
                        state       <= RESP;
                    end else if (timer == 8'(TIMEOUT - 1)) begin
                        rsp_product <= 16'd0;
                        rsp_err     <= 1'b1;
                        rsp_id      <= id;
                        state       <= RESP;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                RESP: begin
                    last_grant <= id;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == LAUNCH) req_ready[id] = 1'b1;
    end

    assign mult_start = (state == LAUNCH);
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);
    assign state_out  = state;

endmodule
